// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle shared by the scanner and its consumer.
// The master side is the scanner: it reads the rows and drives the columns and key outputs.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (input row, output col, key_code, key_valid, key_down);
  modport slave  (output row, input col, key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column per window, rows sampled at window end,
// presses and releases debounced over consecutive scans of a held column.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_row_meta, r_row_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col_idx, w_col_idx_nxt;
  logic [3:0]       r_col;
  logic [3:0]       r_cand, w_cand_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_key_code, w_key_code_nxt;
  logic             r_key_valid, w_key_valid_nxt;
  logic             r_key_down, w_key_down_nxt;
  logic             w_tick;
  logic             w_any_low;
  logic [1:0]       w_row_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
      r_div      <= '0;
    end else begin
      r_row_meta <= bus.row;
      r_row_sync <= r_row_meta;
      r_div      <= w_tick ? '0 : r_div + DIV_W'(1);
    end
  end

  assign w_tick    = (r_div == DIV_LAST);
  assign w_any_low = ~&r_row_sync;

  // Descending scan so the lowest-indexed low row is the one left standing.
  always_comb begin
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_sync[i]) w_row_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_col_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_cand      <= 4'd0;
      r_cnt       <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_col       <= ~(4'b0001 << w_col_idx_nxt);
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_down  <= w_key_down_nxt;
    end
  end

  // NOTE: every next-state signal gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_col_idx_nxt   = r_col_idx;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_down_nxt  = r_key_down;

    if (w_tick) begin
      unique case (r_state)
        ST_SCAN: begin
          if (w_any_low) begin
            if (DEBOUNCE_SCANS == 1) begin
              w_key_code_nxt  = {w_row_idx, r_col_idx};
              w_key_valid_nxt = 1'b1;
              w_key_down_nxt  = 1'b1;
              w_cnt_nxt       = '0;
              w_state_nxt     = ST_HELD;
            end else begin
              w_cand_nxt  = {w_row_idx, r_col_idx};
              w_cnt_nxt   = CNT_W'(1);
              w_state_nxt = ST_DEBOUNCE;
            end
          end else begin
            w_col_idx_nxt = r_col_idx + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (w_any_low && ({w_row_idx, r_col_idx} == r_cand)) begin
            if (r_cnt >= CNT_LAST) begin
              w_key_code_nxt  = r_cand;
              w_key_valid_nxt = 1'b1;
              w_key_down_nxt  = 1'b1;
              w_cnt_nxt       = '0;
              w_state_nxt     = ST_HELD;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_cnt_nxt     = '0;
            w_col_idx_nxt = r_col_idx + 2'd1;
            w_state_nxt   = ST_SCAN;
          end
        end

        ST_HELD: begin
          // Any low row in the held column, even a different key, keeps the press alive.
          if (w_any_low) begin
            w_cnt_nxt = '0;
          end else if (r_cnt >= CNT_LAST) begin
            w_key_down_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_col_idx_nxt  = r_col_idx + 2'd1;
            w_state_nxt    = ST_SCAN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        default: w_state_nxt = ST_SCAN;
      endcase
    end
  end

  assign bus.col       = r_col;
  assign bus.key_code  = r_key_code;
  assign bus.key_valid = r_key_valid;
  assign bus.key_down  = r_key_down;

endmodule
